// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding and default widths.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter shared by stats blocks; holds at all-ones instead of wrapping.
// Compiled only when PIPE_STAGE_STATS_EN is defined, which is the only build that instantiates it.
`ifdef PIPE_STAGE_STATS_EN
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule : sat_counter
`endif

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and registered in_ready.
// Optional stall statistics counter enabled by PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = out_valid_q & out_ready;

  // Next-state and storage update; flush overrides any coincident handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (issue && accept) begin
          main_d = in_data;
        end else if (issue) begin
          state_d = EMPTY;
        end else if (accept) begin
          state_d = SKID;
          skid_d  = in_data;
        end
      end
      SKID: begin
        if (issue) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RST_VAL;
      skid_q      <= RST_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
  // Counts cycles where a valid item is blocked downstream; flush cycles excluded.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (out_valid_q & ~out_ready & ~flush),
    .out (stall_cnt)
  );
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; stall counter checks run when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] RSTV  = 32'hA5A5_0000;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int checks;
  int failures;

  pipe_stage_skid #(
    .WIDTH   (WIDTH),
    .RST_VAL (RSTV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;

    // Reset held with in_valid asserted
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, RSTV);
`ifdef PIPE_STAGE_STATS_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Single item: visible one cycle after accept
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    step();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_hold_data", out_data, 32'hDEAD_BEEF);

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", out_data, 32'(i));
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure into skid: A, B, C
    in_valid = 1'b1;
    in_data  = 32'h11;
    step();
    check("bp_a_data", out_data, 32'h11);
    out_ready = 1'b0;
    in_data   = 32'h22;
    step();
    check("bp_skid_in_ready", 32'(in_ready), 32'd0);
    check("bp_skid_data", out_data, 32'h11);
    check("bp_skid_valid", 32'(out_valid), 32'd1);
    in_data = 32'h33;
    step();
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    step();
    check("bp_b_data", out_data, 32'h22);
    check("bp_b_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_c_data", out_data, 32'h33);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", 32'(out_valid), 32'd0);

    // Flush while in SKID
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    check("fl_pre_in_ready", 32'(in_ready), 32'd0);
    flush   = 1'b1;
    in_data = 32'h44;
    step();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_out_data", out_data, RSTV);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl_c_dropped", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    check("fl_d_valid", 32'(out_valid), 32'd1);
    check("fl_d_data", out_data, 32'h55);
    in_valid = 1'b0;
    step();
    check("fl_d_alone", 32'(out_valid), 32'd0);

    // Simultaneous issue and accept in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    step();
    check("sim_main_data", out_data, 32'h10);
    out_ready = 1'b1;
    in_data   = 32'h20;
    step();
    check("sim_data", out_data, 32'h20);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    check("sim_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("sim_skid_unused", 32'(out_valid), 32'd0);

    // Asynchronous reset asserted mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", out_data, RSTV);
    step();
    rst = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    // Stall counting, flush exclusion and saturation
    check("st_cleared", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    step();
    in_valid = 1'b0;
    check("st_fill_no_inc", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("st_five", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("st_flush_no_inc", 32'(stall_cnt), 32'd5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("st_refill", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 20; i++) step();
    check("st_saturate", 32'(stall_cnt), 32'd15);
    check("st_still_valid", 32'(out_valid), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_skid
